// File: rtl/fir_run_sequencer_pkg.sv
// Shared types and constants for the FIR run/stop and display-frame sequencer.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CONV_REQ,
    CONV_WAIT,
    SHOW
  } state_e;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;
  localparam logic [3:0] ERR_NIBBLE   = 4'hE;

  localparam logic [1:0] PH_BLANK = 2'd0;
  localparam logic [1:0] PH_HI    = 2'd1;
  localparam logic [1:0] PH_MID   = 2'd2;
  localparam logic [1:0] PH_LO    = 2'd3;

  // Three-digit group shown for a given display phase.
  function automatic logic [11:0] group_sel(input logic [1:0] ph, input logic [35:0] snap);
    case (ph)
      PH_HI:   return snap[35:24];
      PH_MID:  return snap[23:12];
      PH_LO:   return snap[11:0];
      default: return {3{BLANK_NIBBLE}};
    endcase
  endfunction

endpackage

// File: rtl/fir_run_sequencer_if.sv
// Converter handshake and display bus of the sequencer.
// master = sequencer side, slave = converter/display side.
interface fir_run_sequencer_if;
  logic        run;
  logic        sample_stb;
  logic        conv_start;
  logic        conv_done;
  logic [35:0] bcd_in;
  logic [11:0] digits;
  logic [1:0]  phase;
  logic        err;

  modport master (
    input  conv_done, bcd_in,
    output run, sample_stb, conv_start, digits, phase, err
  );

  modport slave (
    output conv_done, bcd_in,
    input  run, sample_stb, conv_start, digits, phase, err
  );
endinterface

// File: rtl/fir_run_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle
// press pulse on every accepted released->pressed transition.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q, level_q, press_q;
  logic [CW-1:0] cnt_q;

  // Synchronize, then accept a new level after DEBOUNCE_CYC consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;
endmodule

// File: rtl/fir_run_sequencer.sv
// Run/stop and frame controller for the FIR demo datapath.
// Optional build macro FIR_SEQ_HOLD_EN: on stop the display freezes
// instead of blanking.
module fir_run_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TICK_DIV     = 25000000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic                CLOCK_50,
  input  logic                rst,
  input  logic                btn_n,
  fir_run_sequencer_if.master bus
);
  localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TOW = $clog2(CONV_TIMEOUT + 1);

  logic           press;
  logic           tick;
  logic [TCW-1:0] tick_cnt_q;

  state_e         state_q, state_d;
  logic           run_q, run_d;
  logic           err_q, err_d;
  logic [1:0]     phase_q, phase_d;
  logic [11:0]    digits_q, digits_d;
  logic [35:0]    snap_q, snap_d;
  logic [TOW-1:0] tmo_q, tmo_d;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
    .clk     (CLOCK_50),
    .rst     (rst),
    .btn_n_i (btn_n),
    .press_o (press)
  );

  assign tick = run_q && (tick_cnt_q == TCW'(TICK_DIV - 1));

  // Display tick divider; parked at zero whenever the sequencer is stopped.
  always_ff @(posedge CLOCK_50) begin
    if (rst || !run_q) tick_cnt_q <= '0;
    else if (tick)     tick_cnt_q <= '0;
    else               tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      phase_q  <= PH_BLANK;
      digits_q <= {3{BLANK_NIBBLE}};
      snap_q   <= {9{BLANK_NIBBLE}};
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      err_q    <= err_d;
      phase_q  <= phase_d;
      digits_q <= digits_d;
      snap_q   <= snap_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next state: a press (start or stop) overrides everything, including a coincident tick.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    err_d    = err_q;
    phase_d  = phase_q;
    digits_d = digits_q;
    snap_d   = snap_q;
    tmo_d    = tmo_q;
    if (press) begin
      run_d = ~run_q;
      if (run_q) begin
        state_d = IDLE;
`ifndef FIR_SEQ_HOLD_EN
        phase_d  = PH_BLANK;
        digits_d = {3{BLANK_NIBBLE}};
`endif
      end else begin
        state_d  = SAMPLE;
        err_d    = 1'b0;
        phase_d  = PH_BLANK;
        digits_d = {3{BLANK_NIBBLE}};
      end
    end else begin
      case (state_q)
        SAMPLE: state_d = CONV_REQ;
        CONV_REQ: begin
          // tmo counts cycles elapsed since the conv_start cycle
          tmo_d   = TOW'(1);
          state_d = CONV_WAIT;
        end
        CONV_WAIT: begin
          if (bus.conv_done) begin
            snap_d   = bus.bcd_in;
            phase_d  = PH_BLANK;
            digits_d = {3{BLANK_NIBBLE}};
            state_d  = SHOW;
          end else if (tmo_q >= TOW'(CONV_TIMEOUT - 1)) begin
            err_d    = 1'b1;
            snap_d   = {9{ERR_NIBBLE}};
            phase_d  = PH_BLANK;
            digits_d = {3{BLANK_NIBBLE}};
            state_d  = SHOW;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        SHOW: begin
          if (tick) begin
            if (phase_q == PH_LO) begin
              state_d = SAMPLE;
            end else begin
              phase_d  = phase_q + 2'd1;
              digits_d = group_sel(phase_q + 2'd1, snap_q);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.run        = run_q;
  assign bus.sample_stb = (state_q == SAMPLE);
  assign bus.conv_start = (state_q == CONV_REQ);
  assign bus.digits     = digits_q;
  assign bus.phase      = phase_q;
  assign bus.err        = err_q;
endmodule
